// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared FSM state type and default geometry for the arbitrated RAM.
package ram_port_arbiter_pkg;
   localparam int AW_DEF = 10;
   localparam int DW_DEF = 4;
   typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/ram_sp_regaddr.sv
// ram_sp_regaddr: single-port RAM, synchronous write, registered read address.
module ram_sp_regaddr
   import ram_port_arbiter_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] raddr_q;
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) raddr_q <= addr;
   end
   assign rdata = mem[raddr_q];
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester round-robin front end to a single-port RAM,
// with a power-up clear sweep and a fixed two-cycle read-return pipeline.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ0,
   input  logic          REQ1,
   input  logic          WE0,
   input  logic          WE1,
   input  logic [AW-1:0] ADDR0,
   input  logic [AW-1:0] ADDR1,
   input  logic [DW-1:0] WDATA0,
   input  logic [DW-1:0] WDATA1,
   output logic          GNT0,
   output logic          GNT1,
   output logic          RVALID0,
   output logic          RVALID1,
   output logic [DW-1:0] RDATA,
   output logic          BUSY
);
   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          ptr_q, ptr_d;
   logic          rd_v_q, rd_v_d;
   logic          rd_tag_q, rd_tag_d;
   logic [1:0]    rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          init, taken, sel_we, ram_we, ram_re;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wd, ram_rd;

   always_comb begin
      init     = state_q == INIT;
      GNT0     = !init && REQ0 && (!REQ1 || !ptr_q);
      GNT1     = !init && REQ1 && (!REQ0 || ptr_q);
      taken    = GNT0 || GNT1;
      sel_we   = GNT1 ? WE1 : WE0;
      // The clear sweep owns the RAM port while INIT is active.
      ram_we   = init || (taken && sel_we);
      ram_re   = taken && !sel_we;
      ram_addr = init ? cnt_q : (GNT1 ? ADDR1 : ADDR0);
      ram_wd   = init ? '0 : (GNT1 ? WDATA1 : WDATA0);
      cnt_d    = init ? cnt_q + 1'b1 : cnt_q;
      state_d  = (init && &cnt_q) ? RUN : state_q;
      ptr_d    = taken ? GNT0 : ptr_q;
      rd_v_d   = ram_re;
      rd_tag_d = GNT1;
      rvalid_d = {rd_v_q && rd_tag_q, rd_v_q && !rd_tag_q};
      rdata_d  = rd_v_q ? ram_rd : rdata_q;
      RVALID0  = rvalid_q[0];
      RVALID1  = rvalid_q[1];
      RDATA    = rdata_q;
      BUSY     = init;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= INIT;
         cnt_q    <= '0;
         ptr_q    <= 1'b0;
         rd_v_q   <= 1'b0;
         rd_tag_q <= 1'b0;
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         rd_v_q   <= rd_v_d;
         rd_tag_q <= rd_tag_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   ram_sp_regaddr #(.AW(AW), .DW(DW)) u_ram (
      .clk   (CLK),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wd),
      .rdata (ram_rd)
   );
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vectors with hand-computed expectations for ram_port_arbiter.
module tb_ram_port_arbiter;
   localparam int AW = 10;
   localparam int DW = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          REQ0, REQ1, WE0, WE1;
   logic [AW-1:0] ADDR0, ADDR1;
   logic [DW-1:0] WDATA0, WDATA1;
   logic          GNT0, GNT1, RVALID0, RVALID1, BUSY;
   logic [DW-1:0] RDATA;
   int            n_tests = 0;
   int            n_fail = 0;

   ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
      .CLK(CLK), .RST(RST),
      .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
      .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
      .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
      .RDATA(RDATA), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Counts sampled cycles with BUSY high, starting at the release cycle.
   task automatic init_len(input string tag);
      int n;
      int g;
      n = 0;
      g = 0;
      while (BUSY === 1'b1 && n < 2000) begin
         if (GNT0 || GNT1) g++;
         n++;
         @(negedge CLK);
         #1;
      end
      check({tag, "_len"}, n, 1024);
      check({tag, "_gnt"}, g, 0);
   endtask

   initial begin
      int v;
      int b;
      RST = 1'b1;
      REQ0 = 1'b1; REQ1 = 1'b1; WE0 = 1'b0; WE1 = 1'b0;
      ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
      @(negedge CLK); #1;
      check("rst_busy", BUSY, 1);
      check("rst_gnt0", GNT0, 0);
      check("rst_gnt1", GNT1, 0);
      check("rst_rv", {RVALID1, RVALID0}, 0);
      check("rst_rdata", RDATA, 0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      init_len("init1");
      REQ0 = 1'b0; REQ1 = 1'b0;

      // read after clear returns 0
      @(negedge CLK); REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 10'd777; #1;
      check("rd0_gnt", GNT0, 1);
      @(negedge CLK); REQ0 = 1'b0; #1;
      check("rd0_lat1", RVALID0, 0);
      @(negedge CLK); #1;
      check("rd0_valid", RVALID0, 1);
      check("rd0_data", RDATA, 0);

      // write then read same address next cycle
      @(negedge CLK); REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 10'd5; WDATA0 = 4'hA; #1;
      check("wr5_gnt", GNT0, 1);
      @(negedge CLK); WE0 = 1'b0; #1;
      check("rd5_gnt", GNT0, 1);
      @(negedge CLK); REQ0 = 1'b0; #1;
      check("rd5_lat1", RVALID0, 0);
      @(negedge CLK); #1;
      check("rd5_valid", RVALID0, 1);
      check("rd5_data", RDATA, 4'hA);
      @(negedge CLK); #1;
      check("rd5_strobe_end", RVALID0, 0);
      check("rd5_hold", RDATA, 4'hA);

      // port1 fills addr i with 7-i, then streams reads back-to-back
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK); REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = AW'(i); WDATA1 = DW'(7 - i); #1;
         check($sformatf("fill_gnt%0d", i), GNT1, 1);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         REQ1 = c < 8; WE1 = 1'b0; ADDR1 = AW'(c);
         #1;
         if (c < 8) check($sformatf("str_gnt%0d", c), GNT1, 1);
         if (c >= 2) begin
            check($sformatf("str_rv%0d", c - 2), RVALID1, 1);
            check($sformatf("str_data%0d", c - 2), RDATA, 7 - (c - 2));
         end
      end

      // both ports contend: strict alternation starting with port0
      ADDR0 = 10'd1; ADDR1 = 10'd2; WE0 = 1'b0; WE1 = 1'b0;
      for (int c = 0; c < 9; c++) begin
         @(negedge CLK);
         REQ0 = c < 6; REQ1 = c < 6;
         #1;
         if (c < 6) check($sformatf("rr_gnt%0d", c), {GNT1, GNT0}, (c % 2 == 0) ? 2'b01 : 2'b10);
         if (c >= 2 && c < 8) begin
            check($sformatf("rr_rv%0d", c - 2), {RVALID1, RVALID0}, (c % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr_data%0d", c - 2), RDATA, (c % 2 == 0) ? 6 : 5);
         end
         if (c == 8) check("rr_rv_idle", {RVALID1, RVALID0}, 0);
      end

      // top address: port1 writes, port0 reads it on the next cycle
      @(negedge CLK); REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 10'd1023; WDATA1 = 4'hF; #1;
      check("top_wr_gnt", GNT1, 1);
      @(negedge CLK); REQ1 = 1'b0; REQ0 = 1'b1; ADDR0 = 10'd1023; #1;
      check("top_rd_gnt", GNT0, 1);
      @(negedge CLK); REQ0 = 1'b0; #1;
      @(negedge CLK); #1;
      check("top_rv", RVALID0, 1);
      check("top_data", RDATA, 4'hF);

      // reset one cycle after a read grant drops the read
      @(negedge CLK); REQ0 = 1'b1; ADDR0 = 10'd0; #1;
      check("abort_gnt", GNT0, 1);
      @(negedge CLK); REQ0 = 1'b0; RST = 1'b1; #1;
      check("abort_rv", RVALID0, 0);
      check("abort_rdata", RDATA, 0);
      check("abort_busy", BUSY, 1);
      @(negedge CLK); RST = 1'b0;
      v = 0;
      b = 0;
      repeat (500) begin
         @(negedge CLK); #1;
         if (RVALID0 || RVALID1) v++;
         if (!BUSY) b++;
      end
      check("abort_no_rv", v, 0);
      check("abort_rdata_after", RDATA, 0);
      check("init_mid_busy", b, 0);

      // reset at counter 500 restarts the full sweep
      REQ0 = 1'b1; REQ1 = 1'b1;
      RST = 1'b1; #1;
      check("mid_rst_busy", BUSY, 1);
      check("mid_rst_gnt", {GNT1, GNT0}, 0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      init_len("init2");
      REQ0 = 1'b0; REQ1 = 1'b0;

      // the second sweep cleared earlier data
      @(negedge CLK); REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 10'd5; #1;
      check("clr_gnt", GNT0, 1);
      @(negedge CLK); REQ0 = 1'b0; #1;
      @(negedge CLK); #1;
      check("clr_rv", RVALID0, 1);
      check("clr_data", RDATA, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
